// File: rtl/mult_seq.sv
// Iterative 64x64 shift-add multiplier: MUL (low half), UMULH and SMULH (high half).
// One multiplier bit per clock; signed ops run on magnitudes and are negated at the end.
module mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  state_t      state_q, state_d;
  logic [63:0] hi_q, hi_d;
  logic [63:0] lo_q, lo_d;
  logic [63:0] mcand_q, mcand_d;
  logic [5:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [63:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [64:0]  sum;
  logic [127:0] prod;
  logic [63:0]  abs_a, abs_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    abs_a    = a[63] ? (64'd0 - a) : a;
    abs_b    = b[63] ? (64'd0 - b) : b;
    sum      = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    prod     = neg_q ? (128'd0 - {hi_q, lo_q}) : {hi_q, lo_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          hi_d    = '0;
          count_d = '0;
          if (op == OP_SMULH) begin
            mcand_d = abs_a;
            lo_d    = abs_b;
            neg_d   = a[63] ^ b[63];
          end else begin
            mcand_d = a;
            lo_d    = b;
            neg_d   = 1'b0;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // the 129-bit {sum, lo} shifted right by one
        {hi_d, lo_d} = {sum, lo_q[63:1]};
        count_d      = count_q + 6'd1;
        if (count_q == 6'd63) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q == OP_UMULH || op_q == OP_SMULH) begin
          result_d = prod[127:64];
        end else begin
          result_d = prod[63:0];
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
